// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, frame constants and timeout helper for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_BITS = 8;
  function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
    return clk_hz / 1000000 * timeout_us;
  endfunction
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: 2-flop synchroniser plus debounce; ports clk, rst, raw in; level (filtered), fall (1-cycle pulse on 1->0) out
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN);
  logic meta, sync, hit;
  logic [CW-1:0] cnt;
  assign hit = sync != level && cnt == CW'(FILTER_LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      cnt <= (sync != level && !hit) ? cnt + 1'b1 : '0;
      level <= hit ? sync : level;
      fall <= hit && level;
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver; in clk, rst, ps2_clk, ps2_data; out scan[7:0], scanrdy, parity_err, frame_err pulses
module ps2_rx import ps2_pkg::*; #(
  parameter int CLK_HZ = 50000000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan,
  output logic       scanrdy,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int TO = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int TW = $clog2(TO);
  state_t state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, scan_n;
  logic par, par_n, rdy_n, perr_n, ferr_n;
  logic [TW-1:0] tcnt;
  logic [1:0] dsync;
  logic clk_lvl, fall, fe, d, tmo;
  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk),
    .rst(rst),
    .raw(ps2_clk),
    .level(clk_lvl),
    .fall(fall)
  );
  assign fe = fall && !clk_lvl;
  assign d = dsync[1];
  assign tmo = state != IDLE && tcnt == TW'(TO - 1);
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    shift_n = shift;
    par_n = par;
    scan_n = scan;
    rdy_n = 1'b0;
    perr_n = 1'b0;
    ferr_n = 1'b0;
    if (fe) begin
      case (state)
        IDLE: begin
          state_n = d == START_BIT ? DATA : IDLE;
          bit_n = 3'd0;
        end
        DATA: begin
          shift_n = {d, shift[7:1]};
          bit_n = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'(DATA_BITS - 1) ? PARITY : DATA;
        end
        PARITY: begin
          par_n = d;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          ferr_n = d != STOP_BIT;
          perr_n = d == STOP_BIT && !(^{shift, par});
          rdy_n = d == STOP_BIT && (^{shift, par});
          scan_n = rdy_n ? shift : scan;
        end
      endcase
    end else if (tmo) begin
      state_n = IDLE;
      ferr_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      shift <= 8'h00;
      par <= 1'b0;
      scan <= 8'h00;
      scanrdy <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= '0;
      dsync <= 2'b11;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      par <= par_n;
      scan <= scan_n;
      scanrdy <= rdy_n;
      parity_err <= perr_n;
      frame_err <= ferr_n;
      tcnt <= (fe || state == IDLE) ? '0 : tcnt + 1'b1;
      dsync <= {dsync[0], ps2_data};
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench for ps2_rx with directed and randomized PS/2 frames
module tb_ps2_rx;
  localparam int FL = 8;
  localparam int TO = 200;
  localparam int HALF = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] scan;
  logic scanrdy, parity_err, frame_err;
  typedef struct {int kind; logic [7:0] d; int lat;} exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_fall = 0;
  logic rst_d = 1'b1;
  logic [7:0] exp_scan = 8'h00;
  logic done = 1'b0;
  logic end_checked = 1'b0;

  always #5 clk = ~clk;

  ps2_rx #(.CLK_HZ(1000000), .TIMEOUT_US(200), .FILTER_LEN(FL)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .scan(scan),
    .scanrdy(scanrdy),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_d <= rst;
  end

  // kind: 0 = scanrdy, 1 = parity_err, 2 = frame_err
  always @(negedge clk) begin
    if (rst_d) begin
      exp_scan = 8'h00;
      checks++;
      if ({scan, scanrdy, parity_err, frame_err} != 11'h0) begin
        fails++;
        $display("FAIL reset_vals: scan=%h rdy=%b perr=%b ferr=%b, want all zero", scan, scanrdy, parity_err, frame_err);
      end
    end else begin
      checks++;
      if (int'(scanrdy) + int'(parity_err) + int'(frame_err) > 1) begin
        fails++;
        $display("FAIL exclusive: rdy=%b perr=%b ferr=%b at cyc %0d", scanrdy, parity_err, frame_err, cyc);
      end
      if (scanrdy || parity_err || frame_err) begin
        int k;
        exp_t e;
        k = scanrdy ? 0 : parity_err ? 1 : 2;
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: kind=%0d at cyc %0d, want none", k, cyc);
        end else begin
          e = q.pop_front();
          if (k != e.kind) begin
            fails++;
            $display("FAIL pulse_kind: got %0d, want %0d at cyc %0d", k, e.kind, cyc);
          end
          checks++;
          if (cyc - last_fall < e.lat - 2 || cyc - last_fall > e.lat + 2) begin
            fails++;
            $display("FAIL latency: got %0d cycles, want %0d +/-2", cyc - last_fall, e.lat);
          end
          if (k == 0) begin
            checks++;
            if (scan != e.d) begin
              fails++;
              $display("FAIL scan_value: got %h, want %h", scan, e.d);
            end
            exp_scan = e.d;
          end
        end
      end
      if (!scanrdy) begin
        checks++;
        if (scan != exp_scan) begin
          fails++;
          $display("FAIL scan_hold: got %h, want %h at cyc %0d", scan, exp_scan, cyc);
        end
      end
      if (done && !end_checked) begin
        end_checked = 1'b1;
        checks++;
        if (q.size() != 0) begin
          fails++;
          $display("FAIL missing_pulses: %0d outstanding, want 0", q.size());
        end
      end
    end
  end

  // gl selects the bit whose preceding clock-high phase carries a 3-cycle low glitch (-1 for none)
  task automatic send_bits(input logic [10:0] b, input int n, input int gl);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      if (i == gl) begin
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop, input int gl);
    int k;
    k = !stop ? 2 : (^{d, par}) ? 0 : 1;
    q.push_back('{k, d, FL + 3});
    send_bits({stop, par, d, 1'b0}, 11, gl);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h1C, 1'b0, 1'b1, -1);
    send(8'hF0, 1'b1, 1'b1, -1);
    send(8'h1C, 1'b0, 1'b1, -1);
    send(8'h29, 1'b1, 1'b1, -1);
    send(8'h29, 1'b0, 1'b0, -1);
    q.push_back('{2, 8'h00, TO + FL + 3});
    send_bits({3'b101, 8'h29}, 5, -1);
    repeat (TO + 60) @(negedge clk);
    send(8'h29, 1'b0, 1'b1, -1);
    send(8'h1C, 1'b0, 1'b1, 0);
    send(8'h1C, 1'b0, 1'b1, 5);
    send_bits({3'b101, 8'hA7}, 6, -1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(8'h45, 1'b0, 1'b1, -1);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int r, g;
      d = 8'($urandom);
      r = int'($urandom_range(0, 9));
      g = int'($urandom_range(0, 20));
      send(d, ~^d ^ (r == 8), r != 9, g > 10 ? -1 : g);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
